// File: rtl/sad_min_select.sv
// Minimum-SAD selector: collects NUM_CAND sums over valid/ready and holds {min, index}.
// Optional early exit on a threshold hit is enabled by defining SAD_MIN_EARLY_EXIT_EN.
module sad_min_select #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_CAND = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  output logic              in_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_min,
  output logic [IDX_W-1:0]  res_idx,
`ifdef SAD_MIN_EARLY_EXIT_EN
  input  logic [DATA_W-1:0] thresh,
  output logic              res_early,
`endif
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam longint unsigned MAX_CAND = 64'd1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  // The candidate counter must never wrap before the last accept.
  if (NUM_CAND < 1 || longint'(NUM_CAND) > MAX_CAND) begin : g_bad_num_cand
    $error("sad_min_select: NUM_CAND must lie in 1..2**IDX_W");
  end

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              early_q, early_d;
  logic              accept;
  logic              hit;

  assign accept = in_valid && (state_q == S_COLLECT);

`ifdef SAD_MIN_EARLY_EXIT_EN
  assign hit = (in_sum <= thresh);
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    min_d   = min_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    early_d = early_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          min_d   = '1;
          idx_d   = '0;
          early_d = 1'b0;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          // Strict compare keeps the earliest index on ties.
          if (in_sum < min_q) begin
            min_d = in_sum;
            idx_d = cnt_q;
          end
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX || hit) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            early_d = hit;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      min_q   <= '1;
      idx_q   <= '0;
      valid_q <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      min_q   <= min_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      early_q <= early_d;
    end
  end

  assign in_ready  = (state_q == S_COLLECT);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = valid_q;
  assign res_min   = min_q;
  assign res_idx   = idx_q;

`ifdef SAD_MIN_EARLY_EXIT_EN
  assign res_early = early_q;
`else
  logic unused_early;
  assign unused_early = early_q ^ hit;
`endif

endmodule
